cfu_cmd_queue: RTL and testbench

Buffered command/response front-end that sits directly upstream of `Cfu`. Decouples the issuing master (CPU-side sequencer or DMA) from the CFU's one-at-a-time `cmd`/`rsp` handshake. Queues commands in a FIFO, issues them to `Cfu` strictly in order with at most one in flight, and collects results in a response FIFO. Issue is credit-gated, so `rsp_ready` is never withheld once a command is in flight.

---
 rtl/cfu_cmd_queue_if.sv | 51 +++++
 rtl/cfu_cmd_queue.sv | 176 +++++++++++++++++
 tb/tb_cfu_cmd_queue.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cfu_cmd_queue_if.sv
// Purpose : bundles the master-side command/result handshakes and the Cfu-side cmd/rsp handshakes of cfu_cmd_queue.
// Ports   : in_* (master command), flush, cmd_* / rsp_* (Cfu), out_* (master result), cmd_level, rsp_level, busy.
// Modports: slave = the queue itself, master = the environment around it (master + Cfu).
interface cfu_cmd_queue_if #(
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4
);
    localparam int CLW = $clog2(CMD_DEPTH + 1);
    localparam int RLW = $clog2(RSP_DEPTH + 1);

    logic           in_valid;
    logic           in_ready;
    logic [9:0]     in_function_id;
    logic [31:0]    in_inputs_0;
    logic [31:0]    in_inputs_1;
    logic           flush;

    logic           cmd_valid;
    logic           cmd_ready;
    logic [9:0]     cmd_payload_function_id;
    logic [31:0]    cmd_payload_inputs_0;
    logic [31:0]    cmd_payload_inputs_1;

    logic           rsp_valid;
    logic           rsp_ready;
    logic [31:0]    rsp_payload_outputs_0;

    logic           out_valid;
    logic           out_ready;
    logic [31:0]    out_data;

    logic [CLW-1:0] cmd_level;
    logic [RLW-1:0] rsp_level;
    logic           busy;

    modport slave (
        input  in_valid, in_function_id, in_inputs_0, in_inputs_1, flush,
               cmd_ready, rsp_valid, rsp_payload_outputs_0, out_ready,
        output in_ready, cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
               cmd_payload_inputs_1, rsp_ready, out_valid, out_data,
               cmd_level, rsp_level, busy
    );

    modport master (
        output in_valid, in_function_id, in_inputs_0, in_inputs_1, flush,
               cmd_ready, rsp_valid, rsp_payload_outputs_0, out_ready,
        input  in_ready, cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
               cmd_payload_inputs_1, rsp_ready, out_valid, out_data,
               cmd_level, rsp_level, busy
    );
endinterface

// File: rtl/cfu_cmd_queue.sv
// Purpose : command FIFO -> single-outstanding Cfu issue FSM -> response FIFO, results in command order.
// Latency : enqueue at edge T, cmd_valid after T+1, earliest result push at T+3 (out_valid after T+3).
// Backpr. : in_ready = !cmd_full && !flush; issue is credit-gated on a free response slot, so rsp_ready is never withheld.
// Ports   : clk, reset_n (async active-low), bus (cfu_cmd_queue_if.slave).

// Small generic FIFO: registered level, synchronous clear, storage reset to zero
// so the head reads 0 out of reset. Push when full / pop when empty are ignored.
module cfu_cmd_queue_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] head_dat,
    output logic [LW-1:0]    level,
    output logic             empty,
    output logic             full
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty    = (level == '0);
    assign full     = (level == LW'(DEPTH));
    assign push_ok  = push_vld && !full;
    assign pop_ok   = pop_rdy && !empty;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;   // depth is a power of 2: natural wrap
            end
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

module cfu_cmd_queue #(
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    cfu_cmd_queue_if.slave  bus
);
    typedef struct packed {
        logic [9:0]  function_id;
        logic [31:0] inputs_0;
        logic [31:0] inputs_1;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t state;
    state_t state_nxt;
    cmd_t   pay_q;
    cmd_t   in_dat;
    cmd_t   cmd_head;
    logic   cmd_push;
    logic   cmd_pop;
    logic   cmd_empty;
    logic   cmd_full;
    logic   rsp_push;
    logic   rsp_pop;
    logic   rsp_empty;
    logic   rsp_full;
    logic [$clog2(CMD_DEPTH+1)-1:0] cmd_lvl;
    logic [$clog2(RSP_DEPTH+1)-1:0] rsp_lvl;

    assign in_dat   = '{function_id: bus.in_function_id,
                        inputs_0:    bus.in_inputs_0,
                        inputs_1:    bus.in_inputs_1};
    // Full blocks enqueue even if the FSM pops on the same edge.
    assign bus.in_ready = !cmd_full && !bus.flush;
    assign cmd_push     = bus.in_valid && bus.in_ready;
    assign rsp_pop      = bus.out_ready && !rsp_empty;

    cfu_cmd_queue_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (bus.flush),
        .push_vld (cmd_push),
        .push_dat (in_dat),
        .pop_rdy  (cmd_pop),
        .head_dat (cmd_head),
        .level    (cmd_lvl),
        .empty    (cmd_empty),
        .full     (cmd_full)
    );

    cfu_cmd_queue_fifo #(.WIDTH(32), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (1'b0),
        .push_vld (rsp_push),
        .push_dat (bus.rsp_payload_outputs_0),
        .pop_rdy  (rsp_pop),
        .head_dat (bus.out_data),
        .level    (rsp_lvl),
        .empty    (rsp_empty),
        .full     (rsp_full)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            pay_q <= '0;
        end else begin
            state <= state_nxt;
            if (cmd_pop) pay_q <= cmd_head;
        end
    end

    // Issue needs a free response slot up front (the credit); since only this
    // block pushes the response FIFO, the WAIT-state push can never overflow.
    // A flush on the same edge wins over the pop.
    always_comb begin
        state_nxt = state;
        cmd_pop   = 1'b0;
        rsp_push  = 1'b0;
        case (state)
            IDLE: begin
                if (!cmd_empty && !rsp_full && !bus.flush) begin
                    cmd_pop   = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.cmd_ready) state_nxt = WAIT;
            end
            WAIT: begin
                if (bus.rsp_valid) begin
                    rsp_push  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decode registered state only: no combinational
    // path from cmd_ready or rsp_valid.
    assign bus.cmd_valid               = (state == ISSUE);
    assign bus.rsp_ready               = (state == WAIT);
    assign bus.busy                    = (state != IDLE);
    assign bus.cmd_payload_function_id = pay_q.function_id;
    assign bus.cmd_payload_inputs_0    = pay_q.inputs_0;
    assign bus.cmd_payload_inputs_1    = pay_q.inputs_1;
    assign bus.out_valid               = !rsp_empty;
    assign bus.cmd_level               = cmd_lvl;
    assign bus.rsp_level               = rsp_lvl;
endmodule

// File: tb/tb_cfu_cmd_queue.sv
// Purpose : self-checking bench for cfu_cmd_queue with a queue-based reference model and a Cfu responder.
// Latency : one call of cycle() per clock; inputs change on the falling edge, outputs checked 1ns after the rising edge.
// Backpr. : the Cfu responder randomises cmd_ready and response latency; out_ready is driven per test.
module tb_cfu_cmd_queue;
    localparam int CD = 4;
    localparam int RD = 4;
    localparam logic [9:0] F_ADD = 10'b0000000111;
    localparam logic [9:0] F_SUB = 10'b0000001111;
    localparam logic [9:0] F_MUL = 10'b0000010111;

    typedef struct packed {
        logic [9:0]  fid;
        logic [31:0] a;
        logic [31:0] b;
    } tcmd_t;

    logic clk;
    logic reset_n;

    cfu_cmd_queue_if #(.CMD_DEPTH(CD), .RSP_DEPTH(RD)) bus ();
    cfu_cmd_queue #(.CMD_DEPTH(CD), .RSP_DEPTH(RD)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [95:0] got_v, input logic [95:0] exp_v);
        n_tests++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
        end
    endtask

    // Reference model: pending commands, one in-flight slot, expected results.
    tcmd_t       q_cmd[$];
    logic [31:0] q_rsp[$];
    int          m_stage;      // 0 none in flight, 1 offered to Cfu, 2 accepted by Cfu
    tcmd_t       m_fly;

    // Cfu responder state and knobs.
    bit          cfu_has;
    logic [31:0] cfu_res;
    int          cfu_dly;
    int          cr_pct  = 100;
    int          lat_min = 0;
    int          lat_max = 0;
    bit          spurious;

    // Statistics.
    int          n_cmd_hs;
    int          cv_cycles;
    int          max_cmd_lvl;
    int          max_rsp_lvl;
    logic [31:0] got[$];
    bit          last_in_hs;

    function automatic logic [31:0] cfu_f(input tcmd_t c);
        case (c.fid)
            F_ADD:   return c.a + c.b;
            F_SUB:   return c.a - c.b;
            F_MUL:   return c.a * c.b;
            default: return c.a ^ c.b ^ {22'd0, c.fid};
        endcase
    endfunction

    function automatic tcmd_t mk(input logic [9:0] f, input logic [31:0] a, input logic [31:0] b);
        tcmd_t c;
        c.fid = f;
        c.a   = a;
        c.b   = b;
        return c;
    endfunction

    task automatic set_cmd(input tcmd_t c);
        bus.in_function_id = c.fid;
        bus.in_inputs_0    = c.a;
        bus.in_inputs_1    = c.b;
    endtask

    task automatic model_clear();
        q_cmd.delete();
        q_rsp.delete();
        got.delete();
        m_stage     = 0;
        m_fly       = '0;
        cfu_has     = 1'b0;
        cfu_dly     = 0;
        spurious    = 1'b0;
        n_cmd_hs    = 0;
        cv_cycles   = 0;
        max_cmd_lvl = 0;
        max_rsp_lvl = 0;
    endtask

    task automatic cfu_drive();
        bus.cmd_ready = (int'($urandom_range(99)) < cr_pct);
        if (spurious) begin
            bus.rsp_valid             = 1'b1;
            bus.rsp_payload_outputs_0 = 32'hdead_beef;
        end else if (cfu_has && cfu_dly == 0) begin
            bus.rsp_valid             = 1'b1;
            bus.rsp_payload_outputs_0 = cfu_res;
        end else begin
            bus.rsp_valid = 1'b0;
            if (cfu_has) cfu_dly--;
        end
    endtask

    task automatic reset_vals(input string pfx);
        chk({pfx, "_cmd_valid"}, bus.cmd_valid, 0);
        chk({pfx, "_rsp_ready"}, bus.rsp_ready, 0);
        chk({pfx, "_out_valid"}, bus.out_valid, 0);
        chk({pfx, "_out_data"},  bus.out_data, 0);
        chk({pfx, "_cmd_level"}, bus.cmd_level, 0);
        chk({pfx, "_rsp_level"}, bus.rsp_level, 0);
        chk({pfx, "_busy"},      bus.busy, 0);
        chk({pfx, "_payload"},   {bus.cmd_payload_function_id, bus.cmd_payload_inputs_0,
                                  bus.cmd_payload_inputs_1}, 0);
        chk({pfx, "_in_ready"},  bus.in_ready, 1);
    endtask

    task automatic check_state();
        chk("cmd_valid", bus.cmd_valid, m_stage == 1);
        chk("rsp_ready", bus.rsp_ready, m_stage == 2);
        chk("busy",      bus.busy, m_stage != 0);
        chk("cmd_level", bus.cmd_level, q_cmd.size());
        chk("rsp_level", bus.rsp_level, q_rsp.size());
        chk("out_valid", bus.out_valid, q_rsp.size() != 0);
        if (q_rsp.size() != 0) chk("out_data", bus.out_data, q_rsp[0]);
        if (m_stage == 1)
            chk("cmd_payload", {bus.cmd_payload_function_id, bus.cmd_payload_inputs_0,
                                bus.cmd_payload_inputs_1}, m_fly);
        if (int'(bus.cmd_level) > max_cmd_lvl) max_cmd_lvl = int'(bus.cmd_level);
        if (int'(bus.rsp_level) > max_rsp_lvl) max_rsp_lvl = int'(bus.rsp_level);
    endtask

    // One clock: drive Cfu, sample pre-edge values, advance model, check.
    task automatic cycle();
        tcmd_t       p_in;
        tcmd_t       p_pay;
        logic        p_in_vld, p_in_rdy, p_flush, p_cmd_vld, p_cmd_rdy;
        logic        p_rsp_vld, p_rsp_rdy, p_out_vld, p_out_rdy;
        logic [31:0] p_out_dat;
        int          cs;
        int          rs;
        bit          pop;
        bit          enq;
        cfu_drive();
        #1;
        p_in      = {bus.in_function_id, bus.in_inputs_0, bus.in_inputs_1};
        p_pay     = {bus.cmd_payload_function_id, bus.cmd_payload_inputs_0, bus.cmd_payload_inputs_1};
        p_in_vld  = bus.in_valid;
        p_in_rdy  = bus.in_ready;
        p_flush   = bus.flush;
        p_cmd_vld = bus.cmd_valid;
        p_cmd_rdy = bus.cmd_ready;
        p_rsp_vld = bus.rsp_valid;
        p_rsp_rdy = bus.rsp_ready;
        p_out_vld = bus.out_valid;
        p_out_rdy = bus.out_ready;
        p_out_dat = bus.out_data;
        cs = q_cmd.size();
        rs = q_rsp.size();
        chk("in_ready", p_in_rdy, (cs < CD) && !p_flush);
        @(posedge clk);
        last_in_hs = p_in_vld && p_in_rdy;
        if (p_cmd_vld) cv_cycles++;
        if (p_cmd_vld && p_cmd_rdy) begin
            n_cmd_hs++;
            cfu_has = 1'b1;
            cfu_res = cfu_f(p_pay);
            cfu_dly = $urandom_range(lat_max, lat_min);
        end
        if (p_rsp_vld && p_rsp_rdy && !spurious) cfu_has = 1'b0;
        if (p_out_vld && p_out_rdy) got.push_back(p_out_dat);
        // Reference rules from the pre-edge view.
        pop = (m_stage == 0) && (cs > 0) && (rs < RD) && !p_flush;
        enq = p_in_vld && (cs < CD) && !p_flush;
        if (p_out_rdy && rs > 0) void'(q_rsp.pop_front());
        case (m_stage)
            0: if (pop) begin m_fly = q_cmd.pop_front(); m_stage = 1; end
            1: if (p_cmd_rdy) m_stage = 2;
            2: if (p_rsp_vld) begin q_rsp.push_back(cfu_f(m_fly)); m_stage = 0; end
            default: m_stage = 0;
        endcase
        if (p_flush) q_cmd.delete();
        if (enq) q_cmd.push_back(p_in);
        #1;
        check_state();
        @(negedge clk);
    endtask

    task automatic enq_cmd(input tcmd_t c);
        bit done = 1'b0;
        set_cmd(c);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            cycle();
            done = last_in_hs;
        end
        bus.in_valid = 1'b0;
        if (!done) chk("enq_timeout", 0, 1);
    endtask

    task automatic drain(input int budget);
        bit done = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < budget && !done; i++) begin
            cycle();
            done = (q_cmd.size() == 0) && (m_stage == 0) && (q_rsp.size() == 0);
        end
        if (!done) chk("drain_timeout", 0, 1);
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        reset_n       = 1'b0;
        model_clear();
        #1;
        reset_vals("rst");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        bit reached;
        logic [9:0] fids [4];
        reset_n                   = 1'b1;
        bus.in_valid              = 1'b0;
        bus.flush                 = 1'b0;
        bus.out_ready             = 1'b0;
        bus.cmd_ready             = 1'b0;
        bus.rsp_valid             = 1'b0;
        bus.rsp_payload_outputs_0 = '0;
        set_cmd('0);
        fids[0] = F_ADD; fids[1] = F_SUB; fids[2] = F_MUL; fids[3] = 10'h2a5;
        #1;
        do_reset();

        // Single ADD.
        cr_pct = 100; lat_min = 0; lat_max = 0;
        bus.out_ready = 1'b1;
        enq_cmd(mk(F_ADD, 5, 3));
        drain(30);
        chk("add_hs", n_cmd_hs, 1);
        chk("add_cnt", got.size(), 1);
        if (got.size() > 0) chk("add_data", got[0], 8);
        chk("add_rsp_peak", max_rsp_lvl, 1);

        // Back-to-back ordering.
        do_reset();
        bus.out_ready = 1'b1;
        enq_cmd(mk(F_ADD, 5, 3));
        enq_cmd(mk(F_SUB, 5, 3));
        enq_cmd(mk(F_MUL, 5, 3));
        drain(60);
        chk("b2b_cnt", got.size(), 3);
        if (got.size() == 3) begin
            chk("b2b_0", got[0], 8);
            chk("b2b_1", got[1], 2);
            chk("b2b_2", got[2], 15);
        end
        chk("b2b_peak", (max_cmd_lvl >= 2) && (max_cmd_lvl <= 3), 1);

        // Credit backpressure.
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) enq_cmd(mk(F_ADD, 32'(i), 32'(10 * i)));
        for (int i = 0; i < 6; i++) cycle();
        chk("credit_issued", n_cmd_hs, 4);
        chk("credit_rsp_level", bus.rsp_level, 4);
        chk("credit_cmd_valid", bus.cmd_valid, 0);
        chk("credit_cmd_level", bus.cmd_level, 4);
        chk("credit_in_ready", bus.in_ready, 0);
        drain(100);
        chk("credit_results", got.size(), 8);
        chk("credit_issued_all", n_cmd_hs, 8);
        for (int i = 0; i < 8 && i < got.size(); i++) chk("credit_data", got[i], 32'(11 * i));

        // Slow Cfu: cmd_ready low for 5 cycles.
        do_reset();
        bus.out_ready = 1'b1;
        cr_pct = 0;
        enq_cmd(mk(F_SUB, 100, 1));
        for (int i = 0; i < 30 && cv_cycles < 5; i++) cycle();
        cr_pct = 100;
        drain(30);
        chk("slow_cv_cycles", cv_cycles, 6);
        chk("slow_hs", n_cmd_hs, 1);
        chk("slow_data", (got.size() == 1) ? got[0] : 32'hffff_ffff, 99);

        // Flush with 3 queued and 1 in WAIT.
        do_reset();
        bus.out_ready = 1'b1;
        lat_min = 12; lat_max = 12;
        for (int i = 0; i < 4; i++) enq_cmd(mk(F_MUL, 32'(i + 2), 3));
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            reached = bus.rsp_ready && (bus.cmd_level == 3);
            if (!reached) cycle();
        end
        chk("flush_setup", reached, 1);
        bus.flush = 1'b1;
        cycle();
        bus.flush = 1'b0;
        chk("flush_level", bus.cmd_level, 0);
        lat_min = 0; lat_max = 0;
        drain(60);
        chk("flush_results", got.size(), 1);
        if (got.size() == 1) chk("flush_data", got[0], 6);

        // Asynchronous reset while in ISSUE.
        do_reset();
        bus.out_ready = 1'b1;
        cr_pct = 0;
        enq_cmd(mk(F_ADD, 7, 9));
        for (int i = 0; i < 10 && !bus.cmd_valid; i++) cycle();
        chk("arst_in_issue", bus.cmd_valid, 1);
        #2;
        reset_n = 1'b0;
        model_clear();
        #1;
        reset_vals("arst");
        spurious = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        spurious = 1'b0;
        cr_pct = 100;
        enq_cmd(mk(F_ADD, 5, 3));
        drain(30);
        chk("arst_add_cnt", got.size(), 1);
        if (got.size() == 1) chk("arst_add_data", got[0], 8);

        // Randomised traffic.
        do_reset();
        cr_pct = 60; lat_min = 0; lat_max = 3;
        for (int i = 0; i < 2000; i++) begin
            bus.in_valid  = (int'($urandom_range(99)) < 60);
            set_cmd(mk(fids[$urandom_range(3)], $urandom, $urandom));
            bus.flush     = (int'($urandom_range(99)) < 3);
            bus.out_ready = (int'($urandom_range(99)) < 70);
            cycle();
        end
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        cr_pct       = 100;
        drain(200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
